// File: rtl/microc_pila.sv
// microc_pila: parametrised microcontroller datapath with
// register file, ALU, zero flag and a hardware return stack.
module microc_pila #(
  parameter int W     = 8,
  parameter int NREG  = 16,
  parameter int PCW   = 10,
  parameter int DEPTH = 4,
  parameter int IW    = 20
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [IW-1:0]                instr,
  input  logic                         s_inc,
  input  logic                         s_inm,
  input  logic                         we,
  input  logic                         wez,
  input  logic [2:0]                   ALUOp,
  input  logic                         s_call,
  input  logic                         s_ret,
  output logic [PCW-1:0]               pc,
  output logic [5:0]                   opcode,
  output logic                         zero,
  output logic [$clog2(DEPTH+1)-1:0]   stk_cnt,
  output logic                         stk_ovf,
  output logic                         stk_unf
);

  localparam int RAW = $clog2(NREG);
  localparam int CW  = $clog2(DEPTH+1);
  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SN  = 1 << PW;

  logic [RAW-1:0] ra1, ra2, wa3, rp1;
  logic [W-1:0]   imm, rd1, rd2, opb, alu;
  logic [PCW-1:0] jaddr, pc_inc, top;
  logic [W-1:0]   rf_q [NREG];
  logic [PCW-1:0] stk_q [SN];
  logic [PCW-1:0] pc_q, pc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           ovf_q, ovf_d;
  logic           unf_q, unf_d;
  logic           zero_q;
  logic           push;
  logic           full, empty;
  logic [PW-1:0]  top_idx, push_idx;
  logic           unused_instr;

  assign ra1    = instr[3*RAW-1:2*RAW];
  assign ra2    = instr[2*RAW-1:RAW];
  assign wa3    = instr[RAW-1:0];
  assign imm    = instr[RAW+W-1:RAW];
  assign jaddr  = instr[PCW-1:0];
  assign opcode = instr[IW-1:IW-6];

  // Some instruction bits only matter to the control unit.
  assign unused_instr = ^instr;

  assign rp1 = s_inm ? wa3 : ra1;
  assign rd1 = (rp1 == '0) ? '0 : rf_q[rp1];
  assign rd2 = (ra2 == '0) ? '0 : rf_q[ra2];
  assign opb = s_inm ? imm : rd2;

  // ALU; all results wrap modulo 2^W.
  always_comb begin
    alu = '0;
    unique case (ALUOp)
      3'b000: alu = rd1;
      3'b001: alu = ~rd1;
      3'b010: alu = rd1 + opb;
      3'b011: alu = rd1 - opb;
      3'b100: alu = rd1 & opb;
      3'b101: alu = rd1 | opb;
      3'b110: alu = -rd1;
      3'b111: alu = -opb;
      default: alu = '0;
    endcase
  end

  // Register file write; r0 is hard-wired to zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (we && wa3 != '0) begin
      rf_q[wa3] <= alu;
    end
  end

  // Zero flag captures the ALU result only when enabled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) zero_q <= 1'b0;
    else if (wez) zero_q <= (alu == '0);
  end

  assign pc_inc   = pc_q + PCW'(1);
  assign full     = (cnt_q == CW'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign top_idx  = PW'(cnt_q - CW'(1));
  assign push_idx = PW'(cnt_q);
  assign top      = stk_q[top_idx];

  // PC and stack next state: return beats call beats inc/jump.
  always_comb begin
    pc_d  = pc_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    push  = 1'b0;
    if (s_ret) begin
      if (!empty) begin
        pc_d  = top;
        cnt_d = cnt_q - CW'(1);
      end else begin
        pc_d  = pc_inc;
        unf_d = 1'b1;
      end
    end else if (s_call) begin
      pc_d = jaddr;
      if (!full) begin
        push  = 1'b1;
        cnt_d = cnt_q + CW'(1);
      end else begin
        ovf_d = 1'b1;
      end
    end else if (s_inc) begin
      pc_d = pc_inc;
    end else begin
      pc_d = jaddr;
    end
  end

  // PC, occupancy and sticky error flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Return-address storage; contents dropped on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SN; i++) stk_q[i] <= '0;
    end else if (push) begin
      stk_q[push_idx] <= pc_inc;
    end
  end

  assign pc      = pc_q;
  assign zero    = zero_q;
  assign stk_cnt = cnt_q;
  assign stk_ovf = ovf_q;
  assign stk_unf = unf_q;

endmodule
